// File: rtl/multiply_booth_seq.sv
// Purpose : iterative radix-2 Booth multiplier, WIDTH x WIDTH -> 2*WIDTH,
//           signed or unsigned per operation.
// Latency : done pulses WIDTH+1 clocks after the accepting edge; one
//           operation per WIDTH+3 cycles.
// Backpressure: start is honoured only in IDLE; requests in RUN/DONE are
//           dropped, not queued.
//
// Ports:
//   clk            rising-edge clock
//   rst_n          synchronous active-low reset
//   start          operation request, accepted only when idle
//   signed_mode    1 = two's complement operands, 0 = unsigned
//   multiplicand_a operand A (sampled at accept)
//   multiplier_b   operand B (sampled at accept)
//   busy           high while iterating
//   done           one-cycle pulse; product valid from this cycle
//   product        2*WIDTH-bit result, held until the next completion/reset

module multiply_booth_seq #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     multiplicand_a,
  input  logic [WIDTH-1:0]     multiplier_b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  // Operands are carried one bit wider than WIDTH so that unsigned inputs
  // become non-negative signed values and the same Booth recoding serves
  // both modes. The accumulator gets one more bit on top of that so that
  // adding or subtracting the extended multiplicand can never overflow.
  localparam int EW = WIDTH + 1;
  localparam int AW = WIDTH + 2;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state;
  logic [EW-1:0] m_reg;   // extended multiplicand
  logic [AW-1:0] acc;     // partial-product accumulator
  logic [EW-1:0] q_reg;   // extended multiplier, shifted out LSB first
  logic          q_m1;    // Booth history bit (q-1)
  logic [CW-1:0] cnt;     // Booth steps already performed

  logic [AW-1:0] m_ext;
  logic [AW-1:0] acc_sum;
  logic [AW-1:0] acc_nxt;
  logic [EW-1:0] q_nxt;
  logic          last_step;

  assign m_ext     = {m_reg[EW-1], m_reg};
  assign last_step = (cnt == CW'(WIDTH));

  // One Booth step: recode {q0, q-1}, add/subtract M into the accumulator,
  // then arithmetic-shift {acc, Q, q-1} right by one.
  always_comb begin
    acc_sum = acc;
    case ({q_reg[0], q_m1})
      2'b01:   acc_sum = acc + m_ext;
      2'b10:   acc_sum = acc - m_ext;
      default: acc_sum = acc;
    endcase
    acc_nxt = {acc_sum[AW-1], acc_sum[AW-1:1]};
    q_nxt   = {acc_sum[0], q_reg[EW-1:1]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      m_reg   <= '0;
      acc     <= '0;
      q_reg   <= '0;
      q_m1    <= 1'b0;
      cnt     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            // Sign- or zero-extend by one bit depending on the mode.
            m_reg <= {signed_mode & multiplicand_a[WIDTH-1], multiplicand_a};
            q_reg <= {signed_mode & multiplier_b[WIDTH-1], multiplier_b};
            acc   <= '0;
            q_m1  <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= S_RUN;
          end
        end

        S_RUN: begin
          acc   <= acc_nxt;
          q_reg <= q_nxt;
          q_m1  <= q_reg[0];
          cnt   <= cnt + 1'b1;
          if (last_step) begin
            // After WIDTH+1 shifts the full product sits in {acc, Q}; the
            // low 2*WIDTH bits are exact for both modes because the true
            // product always fits in 2*WIDTH bits.
            product <= {acc_nxt[WIDTH-2:0], q_nxt};
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= S_DONE;
          end
        end

        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multiply_booth_seq.sv
// Purpose : self-checking bench for multiply_booth_seq at WIDTH=8 and 16.
// Expected products come from an arithmetic reference model or constants,
// queued at issue time and popped by a monitor whenever done is seen.

module tb_multiply_booth_seq;

  logic        clk;
  logic        rst_n;
  logic        start8, start16;
  logic        sm;
  logic [7:0]  a8, b8;
  logic [15:0] a16, b16;
  logic        busy8, done8, busy16, done16;
  logic [15:0] prod8;
  logic [31:0] prod16;

  int checks = 0;
  int errors = 0;
  int ndone8 = 0;
  int ndone16 = 0;

  logic [31:0] q8[$];
  logic [31:0] q16[$];

  multiply_booth_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .signed_mode(sm),
    .multiplicand_a(a8), .multiplier_b(b8),
    .busy(busy8), .done(done8), .product(prod8)
  );

  multiply_booth_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .signed_mode(sm),
    .multiplicand_a(a16), .multiplier_b(b16),
    .busy(busy16), .done(done16), .product(prod16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: interpret operands as signed or unsigned integers, multiply
  // with plain arithmetic, keep the low 2*w bits.
  function automatic logic [31:0] ref_mul(int w, logic [15:0] a, logic [15:0] b, bit s);
    longint ea, eb, p, mask;
    ea = longint'(a);
    eb = longint'(b);
    if (s && a[w-1]) ea = ea - (longint'(1) << w);
    if (s && b[w-1]) eb = eb - (longint'(1) << w);
    p    = ea * eb;
    mask = (longint'(1) << (2 * w)) - 1;
    return 32'(p & mask);
  endfunction

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (done8) begin
        ndone8++;
        if (q8.size() == 0) begin
          checks++; errors++;
          $display("FAIL done8_unexpected got product %h expected no done", prod8);
        end else chk("prod8", {16'h0, prod8}, q8.pop_front());
      end
      if (done16) begin
        ndone16++;
        if (q16.size() == 0) begin
          checks++; errors++;
          $display("FAIL done16_unexpected got product %h expected no done", prod16);
        end else chk("prod16", prod16, q16.pop_front());
      end
    end
  endtask

  // mode 0: plain op; 1: pulse start with altered operands mid-run;
  // 2: assert reset after four Booth steps.
  task automatic run_op(int w, logic [15:0] a, logic [15:0] b, bit s,
                        logic [31:0] exp, int mode);
    int cyc;
    bit busy_ok, seen;
    @(negedge clk);
    sm = s;
    if (w == 8) begin
      a8 = a[7:0]; b8 = b[7:0]; start8 = 1'b1; q8.push_back(exp);
    end else begin
      a16 = a; b16 = b; start16 = 1'b1; q16.push_back(exp);
    end
    @(negedge clk);                 // accept edge has passed
    start8 = 1'b0; start16 = 1'b0;
    if (mode == 1) begin a8 = ~a8; b8 = ~b8; sm = ~sm; end
    cyc = 0; busy_ok = 1'b1; seen = 1'b0;
    while (cyc < 40 && !seen) begin
      seen = (w == 8) ? done8 : done16;
      if (!seen) begin
        if (!((w == 8) ? busy8 : busy16)) busy_ok = 1'b0;
        if (mode == 1 && cyc == 4) begin start8 = 1'b1; a8 = 8'h03; b8 = 8'h05; end
        if (mode == 1 && cyc == 5) start8 = 1'b0;
        if (mode == 2 && cyc == 4) begin
          rst_n = 1'b0;
          @(negedge clk);
          rst_n = 1'b1;
          if (w == 8) begin
            void'(q8.pop_back());
            chk("rst_busy", {31'h0, busy8}, 32'h0);
            chk("rst_done", {31'h0, done8}, 32'h0);
            chk("rst_product", {16'h0, prod8}, 32'h0);
          end else begin
            void'(q16.pop_back());
            chk("rst_busy16", {31'h0, busy16}, 32'h0);
            chk("rst_done16", {31'h0, done16}, 32'h0);
            chk("rst_product16", prod16, 32'h0);
          end
          return;
        end
        @(negedge clk);
        cyc++;
      end
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL timeout w=%0d got no done expected done within 40 cycles", w);
      if (w == 8) void'(q8.pop_back()); else void'(q16.pop_back());
      return;
    end
    chk("latency", 32'(cyc), 32'(w + 1));
    chk("busy_during_run", {31'h0, busy_ok}, 32'h1);
    chk("busy_at_done", {31'h0, ((w == 8) ? busy8 : busy16)}, 32'h0);
    @(negedge clk);
    chk("done_width", {31'h0, ((w == 8) ? done8 : done16)}, 32'h0);
    chk("product_hold", ((w == 8) ? {16'h0, prod8} : prod16), exp);
  endtask

  initial begin
    logic [15:0] ra, rb;
    bit rs;
    int n8;
    rst_n = 1'b0; start8 = 1'b0; start16 = 1'b0; sm = 1'b0;
    a8 = '0; b8 = '0; a16 = '0; b16 = '0;
    fork monitor(); join_none
    repeat (3) @(negedge clk);
    chk("reset_busy8", {31'h0, busy8}, 32'h0);
    chk("reset_done8", {31'h0, done8}, 32'h0);
    chk("reset_prod8", {16'h0, prod8}, 32'h0);
    chk("reset_busy16", {31'h0, busy16}, 32'h0);
    chk("reset_done16", {31'h0, done16}, 32'h0);
    chk("reset_prod16", prod16, 32'h0);
    rst_n = 1'b1;

    // Directed WIDTH=8 cases with constant expectations.
    run_op(8, 16'h80, 16'h80, 1'b1, 32'h4000, 0);
    repeat (3) @(negedge clk);
    chk("prod8_held_idle", {16'h0, prod8}, 32'h4000);
    run_op(8, 16'hFF, 16'hFF, 1'b1, 32'h0001, 0);
    run_op(8, 16'hFF, 16'hFF, 1'b0, 32'hFE01, 0);
    run_op(8, 16'h7F, 16'h80, 1'b1, 32'hC080, 0);
    run_op(8, 16'h7F, 16'h80, 1'b0, 32'h3F80, 0);

    // Signed power-of-two squares, positive and negative.
    for (int k = 0; k < 7; k++) begin
      logic [15:0] v;
      v = 16'(1 << k);
      run_op(8, v, v, 1'b1, 32'(1) << (2 * k), 0);
      if (k > 0) begin
        v = 16'(256 - (1 << k));
        run_op(8, v, v, 1'b1, 32'(1) << (2 * k), 0);
      end
    end

    // Start pulse mid-run with different operands must be ignored.
    n8 = ndone8;
    run_op(8, 16'h11, 16'h22, 1'b1, 32'h0242, 1);
    repeat (15) @(negedge clk);
    chk("ignored_start_dones", 32'(ndone8 - n8), 32'd1);
    chk("ignored_start_queue", 32'(q8.size()), 32'd0);

    // Reset in the middle of an operation, then a fresh operation.
    n8 = ndone8;
    run_op(8, 16'h5A, 16'hC3, 1'b1, ref_mul(8, 16'h5A, 16'hC3, 1'b1), 2);
    repeat (12) @(negedge clk);
    chk("reset_abandon_dones", 32'(ndone8 - n8), 32'd0);
    run_op(8, 16'h02, 16'h03, 1'b1, 32'h0006, 0);

    // Random WIDTH=8 vectors against the reference model.
    for (int i = 0; i < 200; i++) begin
      ra = 16'($urandom_range(0, 255));
      rb = 16'($urandom_range(0, 255));
      rs = 1'($urandom_range(0, 1));
      run_op(8, ra, rb, rs, ref_mul(8, ra, rb, rs), 0);
    end

    // WIDTH=16 directed cases.
    run_op(16, 16'h8000, 16'h8000, 1'b1, 32'h40000000, 0);
    run_op(16, 16'hFFFF, 16'h0001, 1'b1, 32'hFFFFFFFF, 0);
    run_op(16, 16'hFFFF, 16'h0001, 1'b0, 32'h0000FFFF, 0);
    run_op(16, 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, 0);

    // Random WIDTH=16 vectors in both modes.
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rs = 1'(i & 1);
      run_op(16, ra, rb, rs, ref_mul(16, ra, rb, rs), 0);
    end

    repeat (5) @(negedge clk);
    chk("queue8_drained", 32'(q8.size()), 32'd0);
    chk("queue16_drained", 32'(q16.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
